round_key_bank: RTL
===================

// Module: round_key_bank
// PURPOSE
// - Captures the cipher key plus the 10 round keys from the key-expansion pipeline
//   (key_expan / valid_out) into an 11-entry register bank.
// - Serves keys by round index to the downstream cipher round engine over a
//   request/valid read port.
// - Sits directly downstream of key expansion; the same key_load pulse that drives
//   expansion valid_in marks a new key here.
// PARAMETERS
// - KEY_LEN        128  width of one round key in bits
// - NUMS_OF_ROUND  10   expansion stages; the bank holds NUMS_OF_ROUND+1 entries
// - ADDR_W         4    round-index width; must satisfy 2**ADDR_W >= NUMS_OF_ROUND+1
// PORTS
// - clk        in   1                      system clock, rising edge
// - reset      in   1                      synchronous, active-high
// - key_in     in   KEY_LEN                cipher key; stored as round key 0
// - key_load   in   1                      1-cycle pulse; same cycle as expansion valid_in
// - key_expan  in   NUMS_OF_ROUND*KEY_LEN  stage i output at bits [(i+1)*KEY_LEN-1 : i*KEY_LEN]
// - exp_valid  in   NUMS_OF_ROUND          per-stage valid from expansion; bit i -> entry i+1
// - rk_req     in   1                      read request
// - rk_addr    in   ADDR_W                 round index, 0..NUMS_OF_ROUND
// - rk_valid   out  1                      read response strobe
// - rk_data    out  KEY_LEN                round key; 0 on a miss
// - rk_miss    out  1                      with rk_valid: entry not captured, or address out of range
// - bank_ready out  1                      all NUMS_OF_ROUND+1 entries hold the current key set
// - busy       out  1                      fill in progress
// - load_err   out  1                      1-cycle pulse: key_load rejected because busy
// BEHAVIOUR
// - Reset: every output 0; capture mask 0; state IDLE. Bank contents are don't-care
//   but must never be returned while their mask bit is 0.
// - FSM states: IDLE, FILL, READY.
//   - IDLE/READY + key_load -> FILL. Store key_in in entry 0. Set mask = 1 (bit 0 only).
//     Clear exp_valid edge history. busy=1 and bank_ready=0 from the next cycle.
//   - FILL + key_load -> stay in FILL. Load is ignored; load_err pulses next cycle.
//   - FILL: on a rising edge of exp_valid[i] (edge history register), store
//     key_expan slice i into entry i+1 and set mask[i+1]. Edges on several bits in the
//     same cycle are all captured. A level held high does not recapture.
//   - FILL -> READY in the cycle after the mask becomes all-ones.
//     Then bank_ready=1 and busy=0.
//   - exp_valid edges seen in IDLE/READY are ignored; the bank is not modified.
// - Read port: fixed 1-cycle latency, no backpressure. A req in cycle N gives rk_valid=1
//   in cycle N+1, one response per req, back-to-back reads allowed.
//   - Hit (addr <= NUMS_OF_ROUND and mask[addr]=1): rk_data = entry, rk_miss=0.
//   - Miss (addr > NUMS_OF_ROUND or mask bit 0): rk_data = 0, rk_miss=1.
//   - Reads are legal in any state. In FILL, already-captured entries return hits.
//   - When rk_valid=0, rk_data holds its last value.
// - Simultaneous key_load and rk_req in READY: the read sees pre-load contents (old key),
//   because read sampling and the entry-0 overwrite happen on the same edge.
// - Simultaneous exp_valid edge and rk_req for the same entry in FILL: returns a miss.
//   The capture becomes visible from the next cycle.
// - Reset mid-FILL: back to IDLE with mask 0; all later reads miss until a new key_load.
// - Arithmetic: mask all-ones compare is on NUMS_OF_ROUND+1 bits. Address range check
//   is unsigned on ADDR_W bits. Widths are not truncated.
// STRUCTURE
// - Shared package aes_pkg: KEY_LEN, NUMS_OF_ROUND, ADDR_W defaults; FSM state
//   encoding localparams (IDLE=2'd0, FILL=2'd1, READY=2'd2).
// - Sub-module round_key_regfile: (NUMS_OF_ROUND+1) x KEY_LEN storage.
//   Ports: one write port for entry 0, NUMS_OF_ROUND parallel slice write enables,
//   one registered read port.
// - Top level holds the FSM, edge detect, mask and miss logic.
// TESTING
// - Load FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, drive expansion model ->
//   bank_ready=1; addr 1 reads a0fafe1788542cb123a339392a6c7605;
//   addr 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6.
// - Read addr 0 in the cycle after key_load -> rk_valid=1, rk_miss=0,
//   rk_data = 2b7e1516..09cf4f3c. Read addr 5 in that same cycle -> rk_miss=1,
//   rk_data=0.
// - Second key_load during FILL -> load_err=1 for one cycle; contents and state
//   unchanged; bank_ready still rises with the first key's set.
// - key_load + rk_req(addr 3) together in READY -> response is the old key's round 3;
//   the next read of addr 3 misses until the new stage 2 valid arrives.
// - Assert reset while 4 entries are captured -> outputs 0, IDLE; reads of addr 0..10
//   all return rk_miss=1.
// - Read addr 11 and addr 15 -> rk_valid=1, rk_miss=1, rk_data=0.
//   exp_valid held high for 3 cycles -> exactly one capture.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES key datapath: default key geometry and the
// round-key bank FSM encoding.
package aes_pkg;

  localparam int KEY_LEN       = 128;
  localparam int NUMS_OF_ROUND = 10;
  localparam int ADDR_W        = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] READY = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_FILL  = FILL,
    ST_READY = READY
  } bank_state_t;

endpackage

// File: rtl/round_key_bank_if.sv
// Round-key bank bus: key load and expansion capture on the upstream side,
// request/valid round-key read port on the downstream side.
interface round_key_bank_if #(
  parameter int KEY_LEN       = aes_pkg::KEY_LEN,
  parameter int NUMS_OF_ROUND = aes_pkg::NUMS_OF_ROUND,
  parameter int ADDR_W        = aes_pkg::ADDR_W
);

  logic [KEY_LEN-1:0]               key_in;
  logic                             key_load;
  logic [NUMS_OF_ROUND*KEY_LEN-1:0] key_expan;
  logic [NUMS_OF_ROUND-1:0]         exp_valid;
  logic                             rk_req;
  logic [ADDR_W-1:0]                rk_addr;
  logic                             rk_valid;
  logic [KEY_LEN-1:0]               rk_data;
  logic                             rk_miss;
  logic                             bank_ready;
  logic                             busy;
  logic                             load_err;

  modport master (
    output key_in, key_load, key_expan, exp_valid, rk_req, rk_addr,
    input  rk_valid, rk_data, rk_miss, bank_ready, busy, load_err
  );

  modport slave (
    input  key_in, key_load, key_expan, exp_valid, rk_req, rk_addr,
    output rk_valid, rk_data, rk_miss, bank_ready, busy, load_err
  );

endinterface

// File: rtl/round_key_regfile.sv
// (NUMS_OF_ROUND+1) x KEY_LEN round-key storage. Entry 0 has its own write
// port for the cipher key; entries 1..N are written from expansion slices.
// The read port is registered and returns zero when the caller flags a miss.
module round_key_regfile #(
  parameter int KEY_LEN       = aes_pkg::KEY_LEN,
  parameter int NUMS_OF_ROUND = aes_pkg::NUMS_OF_ROUND,
  parameter int ADDR_W        = aes_pkg::ADDR_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr0_en,
  input  logic [KEY_LEN-1:0]               wr0_data,
  input  logic [NUMS_OF_ROUND-1:0]         slice_we,
  input  logic [NUMS_OF_ROUND*KEY_LEN-1:0] slice_data,
  input  logic                             rd_en,
  input  logic                             rd_hit,
  input  logic [ADDR_W-1:0]                rd_addr,
  output logic [KEY_LEN-1:0]               rd_data_p1
);

  logic [KEY_LEN-1:0] bank_q [NUMS_OF_ROUND+1];
  logic [KEY_LEN-1:0] rd_word;

  // Storage writes: cipher key into entry 0, expansion slice i into entry i+1.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      bank_q[0] <= wr0_data;
    end
    for (int i = 0; i < NUMS_OF_ROUND; i++) begin
      if (slice_we[i]) begin
        bank_q[i+1] <= slice_data[i*KEY_LEN +: KEY_LEN];
      end
    end
  end

  // Read mux; addresses past the last entry select nothing.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i <= NUMS_OF_ROUND; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_word = bank_q[i];
      end
    end
  end

  // ---- read stage p1: registered data, held while no request is present ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_p1 <= '0;
    end else if (rd_en) begin
      rd_data_p1 <= rd_hit ? rd_word : '0;
    end
  end

endmodule

// File: rtl/round_key_bank.sv
// Round-key bank: captures the cipher key and the expanded round keys into an
// 11-entry bank, tracks which entries belong to the current key with a capture
// mask, and serves keys by round index with a fixed one-cycle read latency.
module round_key_bank
  import aes_pkg::*;
#(
  parameter int KEY_LEN       = aes_pkg::KEY_LEN,
  parameter int NUMS_OF_ROUND = aes_pkg::NUMS_OF_ROUND,
  parameter int ADDR_W        = aes_pkg::ADDR_W
) (
  input logic              clk,
  input logic              reset,
  round_key_bank_if.slave  bus
);

  bank_state_t              state_q, state_d;
  logic [NUMS_OF_ROUND-1:0] hist_q;
  logic [NUMS_OF_ROUND-1:0] edge_cap;
  logic [NUMS_OF_ROUND:0]   mask_q;
  logic                     mask_full;
  logic                     load_acc;
  logic                     rd_hit;
  logic                     load_err_p1;
  logic                     vld_p1;
  logic                     miss_p1;
  logic [KEY_LEN-1:0]       rd_data_p1;

  assign mask_full = &mask_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, load acceptance and capture enables. Edges are only honoured
  // while filling, so a stray expansion valid never disturbs a finished bank.
  always_comb begin
    state_d  = state_q;
    load_acc = 1'b0;
    edge_cap = '0;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (bus.key_load) begin
          load_acc = 1'b1;
          state_d  = ST_FILL;
        end
      end
      ST_FILL: begin
        edge_cap = bus.exp_valid & ~hist_q;
        if (mask_full) begin
          state_d = ST_READY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture mask and exp_valid edge history; a new key restarts both so the
  // first valid of every stage is seen as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      hist_q <= '0;
    end else if (load_acc) begin
      mask_q <= {{NUMS_OF_ROUND{1'b0}}, 1'b1};
      hist_q <= '0;
    end else begin
      mask_q <= mask_q | {edge_cap, 1'b0};
      hist_q <= bus.exp_valid;
    end
  end

  // Rejected-load flag: a key_load that arrives mid-fill pulses load_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_err_p1 <= 1'b0;
    end else begin
      load_err_p1 <= bus.key_load && (state_q == ST_FILL);
    end
  end

  // Hit when the index names a real entry whose mask bit is set before this
  // edge; captures and reloads on the same edge are therefore not yet visible.
  always_comb begin
    rd_hit = 1'b0;
    for (int i = 0; i <= NUMS_OF_ROUND; i++) begin
      if ((bus.rk_addr == ADDR_W'(i)) && mask_q[i]) begin
        rd_hit = 1'b1;
      end
    end
  end

  // ---- read stage p1: response strobe and miss flag ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      miss_p1 <= 1'b0;
    end else begin
      vld_p1  <= bus.rk_req;
      miss_p1 <= bus.rk_req && !rd_hit;
    end
  end

  round_key_regfile #(
    .KEY_LEN       (KEY_LEN),
    .NUMS_OF_ROUND (NUMS_OF_ROUND),
    .ADDR_W        (ADDR_W)
  ) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .wr0_en     (load_acc),
    .wr0_data   (bus.key_in),
    .slice_we   (edge_cap),
    .slice_data (bus.key_expan),
    .rd_en      (bus.rk_req),
    .rd_hit     (rd_hit),
    .rd_addr    (bus.rk_addr),
    .rd_data_p1 (rd_data_p1)
  );

  assign bus.rk_valid   = vld_p1;
  assign bus.rk_miss    = miss_p1;
  assign bus.rk_data    = rd_data_p1;
  assign bus.busy       = (state_q == ST_FILL);
  assign bus.bank_ready = (state_q == ST_READY);
  assign bus.load_err   = load_err_p1;

endmodule
